// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock handshake supervisor: pulses the PLL reset, qualifies lock, retries on timeout, relocks on loss.
// Optional lock-loss counter is built when PLL_LOCK_SUP_LOSS_CNT_EN is defined; otherwise loss_count is tied to zero.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock,
  output logic       pll_rst,
  output logic       lock_ok,
  output logic       sys_rst,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] loss_count
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 8;
  localparam int unsigned LOSS_W  = 8;

  localparam logic [CNT_W-1:0]   RST_LAST      = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST   = CNT_W'(LOCK_STABLE - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX     = RETRY_W'(MAX_RETRIES);
  localparam logic               RETRY_LIMITED = (MAX_RETRIES != 0);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         sync_q;
  logic               lk;
  logic               pll_rst_d, lock_ok_d, sys_rst_d, fail_d;

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign lk = sync_q[1];

  // State, counters and output registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
      pll_rst <= 1'b1;
      lock_ok <= 1'b0;
      sys_rst <= 1'b1;
      fail    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      pll_rst <= pll_rst_d;
      lock_ok <= lock_ok_d;
      sys_rst <= sys_rst_d;
      fail    <= fail_d;
    end
  end

  // Next-state logic; relock overrides every other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (lk) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + RETRY_W'(1);
          cnt_d   = '0;
          if (RETRY_LIMITED && ((retry_q + RETRY_W'(1)) == RETRY_MAX)) begin
            state_d = FAIL;
          end else begin
            state_d = RESET_PLL;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABILIZE: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!lk) begin
          state_d = RESET_PLL;
          cnt_d   = '0;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    if (relock) begin
      state_d = RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // Outputs decoded from the next state so they move on the same edge as state.
  always_comb begin
    pll_rst_d = (state_d == RESET_PLL);
    lock_ok_d = (state_d == RUN);
    sys_rst_d = (state_d != RUN);
    fail_d    = (state_d == FAIL);
  end

  assign state = 3'(state_q);

`ifdef PLL_LOCK_SUP_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_q;
  logic              loss_inc_c;

  assign loss_inc_c = (state_q == RUN) && !lk && !relock;

  // Saturating count of lock losses observed while running.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (loss_inc_c && (loss_q != {LOSS_W{1'b1}})) begin
      loss_q <= loss_q + LOSS_W'(1);
    end
  end

  assign loss_count = loss_q;
`else
  assign loss_count = LOSS_W'(0);
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: default instance, a MAX_RETRIES=0 instance and a short-timing
// instance used to reach loss_count saturation quickly.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

  localparam logic [2:0] S_RST  = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_STAB = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_FAIL = 3'd4;

  logic refclk = 1'b0;
  always #5 refclk = ~refclk;

  int checks = 0;
  int errors = 0;
  int exp_loss = 0;
  logic [14:0] exp_q[$];
  logic [14:0] e, o;

  // default instance
  logic rst_n, pll_locked, relock;
  logic pll_rst, lock_ok, sys_rst, fail;
  logic [2:0] state;
  logic [7:0] loss_count;

  // MAX_RETRIES = 0 instance
  logic rst_n_z, pll_locked_z, relock_z;
  logic pll_rst_z, lock_ok_z, sys_rst_z, fail_z;
  logic [2:0] state_z;
  logic [7:0] loss_count_z;

  // short-timing instance
  logic rst_n_q, pll_locked_q, relock_q;
  logic pll_rst_q, lock_ok_q, sys_rst_q, fail_q;
  logic [2:0] state_q;
  logic [7:0] loss_count_q;

  pll_lock_supervisor dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .relock(relock),
    .pll_rst(pll_rst), .lock_ok(lock_ok), .sys_rst(sys_rst), .fail(fail),
    .state(state), .loss_count(loss_count)
  );

  pll_lock_supervisor #(.MAX_RETRIES(0)) dut_z (
    .refclk(refclk), .rst_n(rst_n_z), .pll_locked(pll_locked_z), .relock(relock_z),
    .pll_rst(pll_rst_z), .lock_ok(lock_ok_z), .sys_rst(sys_rst_z), .fail(fail_z),
    .state(state_z), .loss_count(loss_count_z)
  );

  pll_lock_supervisor #(.RST_CYCLES(2), .LOCK_TIMEOUT(64), .LOCK_STABLE(4), .MAX_RETRIES(3)) dut_q (
    .refclk(refclk), .rst_n(rst_n_q), .pll_locked(pll_locked_q), .relock(relock_q),
    .pll_rst(pll_rst_q), .lock_ok(lock_ok_q), .sys_rst(sys_rst_q), .fail(fail_q),
    .state(state_q), .loss_count(loss_count_q)
  );

  // Expected output vector {state, pll_rst, lock_ok, sys_rst, fail, loss_count} for a given state.
  function automatic logic [14:0] model(input logic [2:0] st, input int loss);
    logic [7:0] l;
`ifdef PLL_LOCK_SUP_LOSS_CNT_EN
    l = (loss > 255) ? 8'd255 : 8'(loss);
`else
    l = 8'd0;
`endif
    case (st)
      S_RST:   return {st, 4'b1010, l};
      S_RUN:   return {st, 4'b0100, l};
      S_FAIL:  return {st, 4'b0011, l};
      default: return {st, 4'b0010, l};
    endcase
  endfunction

  function automatic logic [14:0] obs_main();
    return {state, pll_rst, lock_ok, sys_rst, fail, loss_count};
  endfunction

  function automatic logic [14:0] obs_z();
    return {state_z, pll_rst_z, lock_ok_z, sys_rst_z, fail_z, loss_count_z};
  endfunction

  function automatic logic [14:0] obs_q();
    return {state_q, pll_rst_q, lock_ok_q, sys_rst_q, fail_q, loss_count_q};
  endfunction

  // Advance n active edges and settle just after the last one.
  task automatic step(input int n = 1);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_n_z = 1'b0; rst_n_q = 1'b0;
    pll_locked = 1'b0; pll_locked_z = 1'b0; pll_locked_q = 1'b0;
    relock = 1'b0; relock_z = 1'b0; relock_q = 1'b0;
    exp_q.push_back(model(S_RST, 0));
    step(5);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset: got %h expected %h", o, e); end
  endtask

  task automatic test_power_up();
    int n;
    rst_n = 1'b1;
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin n++; step(1); end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL pwr_rst_width: got %0d expected 16", n); end
    exp_q.push_back(model(S_WAIT, 0));
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL pwr_wait_lock: got %h expected %h", o, e); end
    step(84);
    pll_locked = 1'b1;
    exp_q.push_back(model(S_WAIT, 0));
    step(2);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL pwr_k2_wait: got %h expected %h", o, e); end
    exp_q.push_back(model(S_STAB, 0));
    step(1);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL pwr_stabilize: got %h expected %h", o, e); end
    exp_q.push_back(model(S_STAB, 0));
    step(255);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL pwr_before_run: got %h expected %h", o, e); end
    exp_q.push_back(model(S_RUN, 0));
    step(1);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL pwr_run: got %h expected %h", o, e); end
  endtask

  task automatic test_lock_loss();
    int n;
    for (int i = 1; i <= 10; i++) begin
      pll_locked = 1'b0;
      exp_q.push_back(model(S_RUN, exp_loss));
      step(1);
      pll_locked = 1'b1;
      step(1);
      e = exp_q.pop_front(); o = obs_main(); checks++;
      if (o !== e) begin errors++; $display("FAIL loss_k2_drop%0d: got %h expected %h", i, o, e); end
      exp_loss++;
      exp_q.push_back(model(S_RST, exp_loss));
      step(1);
      e = exp_q.pop_front(); o = obs_main(); checks++;
      if (o !== e) begin errors++; $display("FAIL loss_k3_drop%0d: got %h expected %h", i, o, e); end
      n = 0;
      while (lock_ok !== 1'b1 && n < 400) begin n++; step(1); end
      checks++;
      if (lock_ok !== 1'b1) begin errors++; $display("FAIL loss_relock_drop%0d: got lock_ok=%b expected 1", i, lock_ok); end
    end
  endtask

  task automatic test_relock_run();
    int n;
    pll_locked = 1'b0;
    relock = 1'b1;
    exp_q.push_back(model(S_RST, exp_loss));
    step(1);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL relock_run: got %h expected %h", o, e); end
    exp_q.push_back(model(S_RST, exp_loss));
    step(19);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL relock_hold: got %h expected %h", o, e); end
    relock = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin n++; step(1); end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL relock_hold_width: got %0d expected 16", n); end
  endtask

  task automatic test_unstable();
    exp_q.push_back(model(S_WAIT, exp_loss));
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL unst_start: got %h expected %h", o, e); end
    pll_locked = 1'b1;
    exp_q.push_back(model(S_STAB, exp_loss));
    step(3);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL unst_stab: got %h expected %h", o, e); end
    step(97);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    exp_q.push_back(model(S_STAB, exp_loss));
    step(1);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL unst_k2_stab: got %h expected %h", o, e); end
    exp_q.push_back(model(S_WAIT, exp_loss));
    step(1);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL unst_drop: got %h expected %h", o, e); end
    exp_q.push_back(model(S_STAB, exp_loss));
    step(1);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL unst_restab: got %h expected %h", o, e); end
    exp_q.push_back(model(S_STAB, exp_loss));
    step(255);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL unst_before_run: got %h expected %h", o, e); end
    exp_q.push_back(model(S_RUN, exp_loss));
    step(1);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL unst_run: got %h expected %h", o, e); end
  endtask

  task automatic test_timeout();
    int n;
    pll_locked = 1'b0;
    relock = 1'b1;
    step(1);
    relock = 1'b0;
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (pll_rst === 1'b1 && n < 100) begin n++; step(1); end
      checks++;
      if (n !== 16) begin errors++; $display("FAIL to_pulse%0d_width: got %0d expected 16", p, n); end
      n = 0;
      while (pll_rst === 1'b0 && fail === 1'b0 && n < 2000) begin n++; step(1); end
      checks++;
      if (n !== 1024) begin errors++; $display("FAIL to_wait%0d_width: got %0d expected 1024", p, n); end
    end
    exp_q.push_back(model(S_FAIL, exp_loss));
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL to_fail: got %h expected %h", o, e); end
    exp_q.push_back(model(S_FAIL, exp_loss));
    step(50);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL to_fail_hold: got %h expected %h", o, e); end
    relock = 1'b1;
    exp_q.push_back(model(S_RST, exp_loss));
    step(1);
    relock = 1'b0;
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL to_relock: got %h expected %h", o, e); end
  endtask

  task automatic test_async_reset();
    int n;
    pll_locked = 1'b1;
    n = 0;
    while (lock_ok !== 1'b1 && n < 400) begin n++; step(1); end
    checks++;
    if (lock_ok !== 1'b1) begin errors++; $display("FAIL async_prelock: got lock_ok=%b expected 1", lock_ok); end
    #3;
    rst_n = 1'b0;
    exp_q.push_back(model(S_RST, 0));
    #1;
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset: got %h expected %h", o, e); end
    exp_q.push_back(model(S_RST, 0));
    step(3);
    e = exp_q.pop_front(); o = obs_main(); checks++;
    if (o !== e) begin errors++; $display("FAIL async_reset_hold: got %h expected %h", o, e); end
  endtask

  task automatic test_max_retries_zero();
    int n;
    pll_locked_z = 1'b0;
    rst_n_z = 1'b1;
    for (int p = 0; p < 20; p++) begin
      n = 0;
      while (pll_rst_z === 1'b1 && n < 100) begin n++; step(1); end
      checks++;
      if (n !== 16) begin errors++; $display("FAIL zr_pulse%0d_width: got %0d expected 16", p, n); end
      n = 0;
      while (pll_rst_z === 1'b0 && fail_z === 1'b0 && n < 2000) begin n++; step(1); end
      checks++;
      if (n !== 1024) begin errors++; $display("FAIL zr_wait%0d_width: got %0d expected 1024", p, n); end
    end
    exp_q.push_back(model(S_RST, 0));
    e = exp_q.pop_front(); o = obs_z(); checks++;
    if (o !== e) begin errors++; $display("FAIL zr_still_retrying: got %h expected %h", o, e); end
  endtask

  task automatic test_back_to_back();
    int n;
    pll_locked_q = 1'b1;
    rst_n_q = 1'b1;
    n = 0;
    while (lock_ok_q !== 1'b1 && n < 100) begin n++; step(1); end
    checks++;
    if (lock_ok_q !== 1'b1) begin errors++; $display("FAIL b2b_initial_lock: got lock_ok=%b expected 1", lock_ok_q); end
    for (int i = 1; i <= 300; i++) begin
      pll_locked_q = 1'b0;
      step(1);
      pll_locked_q = 1'b1;
      exp_q.push_back(model(S_RST, i));
      step(2);
      e = exp_q.pop_front(); o = obs_q(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b_drop%0d: got %h expected %h", i, o, e); end
      n = 0;
      while (lock_ok_q !== 1'b1 && n < 50) begin n++; step(1); end
      checks++;
      if (lock_ok_q !== 1'b1) begin errors++; $display("FAIL b2b_relock%0d: got lock_ok=%b expected 1", i, lock_ok_q); end
    end
    exp_q.push_back(model(S_RUN, 300));
    e = exp_q.pop_front(); o = obs_q(); checks++;
    if (o !== e) begin errors++; $display("FAIL b2b_saturated: got %h expected %h", o, e); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_relock_run();
    test_unstable();
    test_timeout();
    test_async_reset();
    test_max_retries_zero();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Controller for the reset/lock handshake of a wrapped PLL instance. It drives the PLL `rst` input, watches the PLL `locked` output, retries on lock timeout and relocks on lock loss. It qualifies lock with a stability window and releases a synchronous reset to logic clocked from the PLL output. It sits beside every PLL wrapper in the clocking tree and runs on the PLL reference clock.

## Interface
Parameters:
- `RST_CYCLES`, 16: PLL reset pulse width in `refclk` cycles (1..65535).
- `LOCK_TIMEOUT`, 1024: cycles allowed in WAIT_LOCK before a retry (1..65535).
- `LOCK_STABLE`, 256: cycles `locked` must stay high before lock is declared (1..65535).
- `MAX_RETRIES`, 3: consecutive timeouts before FAIL; 0 means retry forever (0..255).

Ports:
- `refclk` in 1: free-running reference clock; the single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pll_locked` in 1: PLL `locked` output; asynchronous, synchronised internally.
- `relock` in 1: single-cycle request to restart the PLL from any state.
- `pll_rst` out 1: drives the PLL `rst` input; active high.
- `lock_ok` out 1: high only in RUN.
- `sys_rst` out 1: active-high reset for downstream logic; low only in RUN.
- `fail` out 1: high only in FAIL.
- `state` out 3: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4.
- `loss_count` out 8: count of lock losses seen in RUN; saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lk`. All decisions use `lk`.
- A 16-bit cycle counter `cnt` and an 8-bit retry counter `retry` drive the state machine.
- Reset values: state=RESET_PLL, cnt=0, retry=0, pll_rst=1, lock_ok=0, sys_rst=1, fail=0, loss_count=0, synchroniser flops=0.
- RESET_PLL:
  - pll_rst=1 and cnt increments each cycle.
  - When cnt==RST_CYCLES-1, go to WAIT_LOCK and set cnt=0.
- WAIT_LOCK:
  - pll_rst=0.
  - If lk=1, go to STABILIZE and set cnt=0.
  - Else, when cnt==LOCK_TIMEOUT-1, increment retry. If MAX_RETRIES≠0 and retry+1==MAX_RETRIES, go to FAIL; otherwise go to RESET_PLL and set cnt=0.
- STABILIZE:
  - If lk=0, go to WAIT_LOCK and set cnt=0. This is not a retry.
  - When cnt==LOCK_STABLE-1 with lk=1, go to RUN and set retry=0.
- RUN:
  - On lk=0, increment loss_count (saturating) and go to RESET_PLL with cnt=0.
- FAIL:
  - pll_rst=0, fail=1, sys_rst=1.
  - Leaves only on `relock` or `rst_n`.
- `relock`=1 has priority over every other transition in every state:
  - Next state is RESET_PLL, with cnt=0 and retry=0.
  - loss_count is unchanged.
- Outputs `pll_rst`, `lock_ok`, `sys_rst` and `fail` are registered. They are decoded from the next state, so they change on the same edge as `state`.

## Timing
- pll_rst stays high throughout `rst_n` low and for exactly RST_CYCLES cycles after `rst_n` rises.
- Every later PLL reset pulse is also exactly RST_CYCLES cycles.
- A `pll_locked` rise sampled at edge k gives lk=1 at edge k+2 and STABILIZE at edge k+3.
- lock_ok=1 and sys_rst=0 follow at edge k+3+LOCK_STABLE.
- A `pll_locked` fall in RUN sampled at edge k:
  - lock_ok=0, sys_rst=1 and pll_rst=1 at edge k+3.
  - loss_count increments on that same edge.
- Glitches shorter than one `refclk` period may be missed. This is acceptable; `pll_locked` is level-qualified.
- `relock` asserted at edge k gives pll_rst=1 at edge k+1.
- Holding `relock` high keeps the block in RESET_PLL with cnt=0.
- If `rst_n` is asserted mid-operation, all outputs go to their reset values immediately (asynchronously).

## Configuration
- `PLL_LOCK_SUP_LOSS_CNT_EN` defined: the loss_count register and its saturation logic are built as described.
- Not defined: `loss_count` is tied to 8'd0 and no counter flops are inferred.
- State machine behaviour is identical either way.

## Test plan
All scenarios use the default parameters.
- Power-up: hold rst_n low 5 cycles, then release with pll_locked rising 100 cycles after release. Expect pll_rst high for 16 cycles after release, lock_ok=1 exactly 3+256 cycles after the pll_locked rise, and retry=0.
- Timeout retry: hold pll_locked=0 forever. Expect 3 pulses of pll_rst, each 16 cycles, separated by 1024-cycle waits. After the third timeout expect state=FAIL, fail=1 and pll_rst=0. Then pulse relock once: expect state=RESET_PLL and fail=0 on the next edge.
- Unstable lock: pll_locked high for 100 cycles, low 1 cycle (sampled), then high. Expect STABILIZE→WAIT_LOCK→STABILIZE with no retry increment, and lock_ok only after 256 continuous lk cycles.
- Lock loss in RUN: drop pll_locked 10 times. Expect loss_count=10, with pll_rst reasserted 3 cycles after each drop. Continue to 300 drops and expect loss_count held at 255. With the macro undefined, expect loss_count=0 throughout.
- Relock in RUN: pulse relock. Expect lock_ok=0, sys_rst=1 and pll_rst=1 on the next edge, and loss_count unchanged.
- MAX_RETRIES=0 build: pll_locked stuck at 0 for 20 timeouts. Expect fail never asserted and pll_rst pulsing continuously.
